mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the processor's single-port main memory. Shares the memory between the CPU datapath (driven by the multicycle control unit's MemRead/MemWrite with IorD-selected address) and an I/O/DMA requester serviced during SYSCALL. It sequences each access against a fixed memory read latency and returns a one-cycle completion pulse. It also produces a stall signal that freezes the control unit until its access completes.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / IO-DMA) arbiter and access sequencer for the single-port main memory.
// Round-robin grant, fixed read latency, one-cycle done pulse per access, CPU stall output.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_done,
   output logic [DATA_W-1:0] io_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

   // CAPT is the cycle in which mem_rdata is valid; it is latched at the CAPT->DONE edge.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CAPT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              owner_io, owner_nxt;
   logic              last_io, last_nxt;
   logic              cmd_we, cmd_we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt, io_rdata_nxt;
   logic              gnt_nxt, done_nxt, mem_en_nxt, mem_we_nxt;
   logic              pick_io;

   assign cpu_stall = cpu_req & ~cpu_done;

   // Next-state, command latch and registered-output computation
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      owner_nxt     = owner_io;
      last_nxt      = last_io;
      cmd_we_nxt    = cmd_we;
      addr_nxt      = mem_addr;
      wdata_nxt     = mem_wdata;
      cpu_rdata_nxt = cpu_rdata;
      io_rdata_nxt  = io_rdata;
      gnt_nxt       = 1'b0;
      done_nxt      = 1'b0;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      pick_io       = (cpu_req && io_req) ? ~last_io : io_req;

      case (state)
         S_IDLE: begin
            if (cpu_req || io_req) begin
               state_nxt  = S_ISSUE;
               owner_nxt  = pick_io;
               last_nxt   = pick_io;
               cmd_we_nxt = pick_io ? io_we : cpu_we;
               addr_nxt   = pick_io ? io_addr : cpu_addr;
               wdata_nxt  = pick_io ? io_wdata : cpu_wdata;
               gnt_nxt    = 1'b1;
               mem_en_nxt = 1'b1;
               mem_we_nxt = pick_io ? io_we : cpu_we;
            end
         end
         S_ISSUE: begin
            gnt_nxt = 1'b1;
            if (cmd_we) begin
               state_nxt = S_DONE;
               done_nxt  = 1'b1;
            end else if (MEM_LAT > 1) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end else begin
               state_nxt = S_CAPT;
            end
         end
         S_WAIT: begin
            gnt_nxt = 1'b1;
            if (cnt == WAIT_LAST) begin
               state_nxt = S_CAPT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_CAPT: begin
            gnt_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
            if (owner_io) io_rdata_nxt  = mem_rdata;
            else          cpu_rdata_nxt = mem_rdata;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight access
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         owner_io  <= 1'b0;
         last_io   <= 1'b1;
         cmd_we    <= 1'b0;
         cpu_gnt   <= 1'b0;
         io_gnt    <= 1'b0;
         cpu_done  <= 1'b0;
         io_done   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         io_rdata  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         owner_io  <= owner_nxt;
         last_io   <= last_nxt;
         cmd_we    <= cmd_we_nxt;
         cpu_gnt   <= gnt_nxt & ~owner_nxt;
         io_gnt    <= gnt_nxt & owner_nxt;
         cpu_done  <= done_nxt & ~owner_nxt;
         io_done   <= done_nxt & owner_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         io_rdata  <= io_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-written arbitration,
// command-stability, reset-abort and MEM_LAT=1 sequences against a latency-accurate memory model.
module tb_mem_arbiter;

   localparam int unsigned LAT = 2;

   logic CLK = 1'b0;
   logic Reset;
   logic mem_init;
   always #5 CLK = ~CLK;

   logic        cpu_req, cpu_we, io_req, io_we;
   logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
   logic        cpu_gnt, cpu_done, cpu_stall, io_gnt, io_done;
   logic [15:0] cpu_rdata, io_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic        b_cpu_req, b_cpu_we, b_io_req, b_io_we;
   logic [15:0] b_cpu_addr, b_cpu_wdata, b_io_addr, b_io_wdata;
   logic        b_cpu_gnt, b_cpu_done, b_cpu_stall, b_io_gnt, b_io_done;
   logic [15:0] b_cpu_rdata, b_io_rdata;
   logic        b_mem_en, b_mem_we;
   logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_done(io_done), .io_rdata(io_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_lat1 (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
      .io_req(b_io_req), .io_we(b_io_we), .io_addr(b_io_addr), .io_wdata(b_io_wdata),
      .io_gnt(b_io_gnt), .io_done(b_io_done), .io_rdata(b_io_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata)
   );

   // Memory model: read data appears exactly LAT cycles after the mem_en cycle, 0xDEAD otherwise
   logic [15:0] mem [0:255];
   logic [15:0] pipe_a [0:LAT-1];
   logic [15:0] pipe_b;

   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h10) return 16'hBEEF;
      return {a, ~a};
   endfunction

   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      pipe_a[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b <= (b_mem_en && !b_mem_we) ? mem[b_mem_addr[7:0]] : 16'hDEAD;
   end
   assign mem_rdata   = pipe_a[LAT-1];
   assign b_mem_rdata = pipe_b;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic        is_io;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          exp_done;
      logic [15:0] exp_rdata;
   } vec_t;

   // Single-requester transaction; starts in an IDLE cycle (cycle 0), ends in cycle done+1
   task automatic run_txn(input int idx, input vec_t v);
      int          done_cyc = -1;
      int          en_cyc = -1;
      int          en_cnt = 0;
      logic        other_gnt = 1'b0;
      logic        stall_bad = 1'b0;
      logic [15:0] is_addr = '0;
      logic [15:0] is_wd = '0;
      logic        is_we = 1'b0;
      logic [15:0] rd = '0;
      string       tag;
      tag = $sformatf("vec%0d", idx);
      if (v.is_io) begin
         io_req = 1'b1; io_we = v.we; io_addr = v.addr; io_wdata = v.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      for (int c = 0; c < 20 && done_cyc < 0; c++) begin
         @(negedge CLK);
         if (mem_en) begin
            en_cnt++;
            if (en_cyc < 0) begin
               en_cyc = c; is_addr = mem_addr; is_we = mem_we; is_wd = mem_wdata;
            end
         end
         if (v.is_io ? cpu_gnt : io_gnt) other_gnt = 1'b1;
         if (v.is_io ? io_done : cpu_done) begin
            done_cyc = c;
            rd = v.is_io ? io_rdata : cpu_rdata;
         end
         if (v.is_io) begin
            if (cpu_stall !== 1'b0) stall_bad = 1'b1;
         end else if (cpu_stall !== ((done_cyc == c) ? 1'b0 : 1'b1)) begin
            stall_bad = 1'b1;
         end
         next_cycle();
      end
      cpu_req = 1'b0;
      io_req  = 1'b0;
      check({tag, "_done_cycle"}, done_cyc, v.exp_done);
      check({tag, "_issue_cycle"}, en_cyc, 1);
      check({tag, "_issue_count"}, en_cnt, 1);
      check({tag, "_mem_addr"}, {16'h0, is_addr}, {16'h0, v.addr});
      check({tag, "_mem_we"}, {31'h0, is_we}, {31'h0, v.we});
      check({tag, "_rdata"}, {16'h0, rd}, {16'h0, v.exp_rdata});
      check({tag, "_other_gnt"}, {31'h0, other_gnt}, 32'h0);
      check({tag, "_stall"}, {31'h0, stall_bad}, 32'h0);
      if (v.we) begin
         check({tag, "_mem_wdata"}, {16'h0, is_wd}, {16'h0, v.wdata});
         check({tag, "_mem_content"}, {16'h0, mem[v.addr[7:0]]}, {16'h0, v.wdata});
      end
   endtask

   function automatic logic [31:0] out_bundle_a();
      return {8'h0, cpu_gnt, io_gnt, cpu_done, io_done, mem_en, mem_we, 2'b0,
              mem_addr | mem_wdata | cpu_rdata | io_rdata};
   endfunction

   vec_t vecs [7];

   initial begin
      int          iss_cyc [3];
      logic        iss_io [3];
      int          n_iss;
      logic        dbl;
      int          cdone [2];
      int          n_cdone;
      int          io_done_cyc;
      logic [15:0] io_rd;
      logic [15:0] addr_c1, addr_c3;
      int          en_after;
      int          done_cyc;
      logic [15:0] rd;

      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 2, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 4, 16'h1234};
      vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'hA5A5, 2, 16'hBEEF};
      vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 4, 16'hA5A5};
      vecs[5] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 4, 16'h33CC};
      vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 4, 16'hFF00};

      Reset = 1'b1; mem_init = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
      b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_io_req = 1'b0; b_io_we = 1'b0; b_io_addr = '0; b_io_wdata = '0;
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      check("reset_outputs_a", out_bundle_a(), 32'h0);
      check("reset_stall_a", {31'h0, cpu_stall}, 32'h0);
      check("reset_outputs_b", {b_cpu_gnt, b_io_gnt, b_cpu_done, b_io_done, b_mem_en, b_mem_we,
                                b_mem_addr | b_mem_wdata | b_cpu_rdata | b_io_rdata}, 32'h0);
      next_cycle();
      Reset = 1'b0; mem_init = 1'b0;

      for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

      // Simultaneous held reads after reset: CPU, IO, CPU with 5-cycle spacing
      Reset = 1'b1;
      next_cycle();
      Reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0033;
      n_iss = 0; dbl = 1'b0; n_cdone = 0; io_done_cyc = -1; io_rd = '0;
      for (int c = 0; c < 15; c++) begin
         @(negedge CLK);
         if (cpu_gnt && io_gnt) dbl = 1'b1;
         if (mem_en && n_iss < 3) begin
            iss_cyc[n_iss] = c; iss_io[n_iss] = io_gnt; n_iss++;
         end
         if (cpu_done && n_cdone < 2) begin
            cdone[n_cdone] = c; n_cdone++;
         end
         if (io_done) begin
            io_done_cyc = c; io_rd = io_rdata;
         end
         next_cycle();
      end
      cpu_req = 1'b0; io_req = 1'b0;
      check("rr_issue_count", n_iss, 3);
      check("rr_first_cpu", {iss_cyc[0][30:0], iss_io[0]}, {31'd1, 1'b0});
      check("rr_second_io", {iss_cyc[1][30:0], iss_io[1]}, {31'd6, 1'b1});
      check("rr_third_cpu", {iss_cyc[2][30:0], iss_io[2]}, {31'd11, 1'b0});
      check("rr_double_grant", {31'h0, dbl}, 32'h0);
      check("rr_cpu_done", {cdone[0][15:0], cdone[1][15:0]}, {16'd4, 16'd14});
      check("rr_io_done", io_done_cyc, 9);
      check("rr_io_rdata", {16'h0, io_rd}, 32'h0000_33CC);

      // Command stability: address changes after grant are ignored
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      addr_c1 = '0; addr_c3 = '0; done_cyc = -1; rd = '0;
      for (int c = 0; c < 8 && done_cyc < 0; c++) begin
         if (c == 1) cpu_addr = 16'h0030;
         @(negedge CLK);
         if (c == 1) addr_c1 = mem_addr;
         if (c == 3) addr_c3 = mem_addr;
         if (cpu_done) begin
            done_cyc = c; rd = cpu_rdata;
         end
         next_cycle();
      end
      cpu_req = 1'b0;
      check("stab_addr_c1", {16'h0, addr_c1}, 32'h0010);
      check("stab_addr_c3", {16'h0, addr_c3}, 32'h0010);
      check("stab_done", done_cyc, 4);
      check("stab_rdata", {16'h0, rd}, 32'h0000_BEEF);

      // Reset in cycle 2 of a CPU read: abandon, clear, then re-issue
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
      en_after = -1; done_cyc = -1; n_cdone = 0; rd = '0;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) Reset = 1'b1;
         if (c == 3) Reset = 1'b0;
         @(negedge CLK);
         if (c == 2) check("rst_stall_during_reset", {31'h0, cpu_stall}, 32'h1);
         if (c == 3) begin
            check("rst_outputs_cleared", out_bundle_a(), 32'h0);
            check("rst_stall_after", {31'h0, cpu_stall}, 32'h1);
         end
         if (c >= 3 && mem_en && en_after < 0) en_after = c;
         if (cpu_done) begin
            n_cdone++; done_cyc = c; rd = cpu_rdata;
         end
         next_cycle();
      end
      cpu_req = 1'b0;
      check("rst_reissue_cycle", en_after, 4);
      check("rst_done_count", n_cdone, 1);
      check("rst_done_cycle", done_cyc, 7);
      check("rst_rdata", {16'h0, rd}, 32'h0000_A5A5);

      // MEM_LAT=1 build: CPU read completes in cycle 3
      next_cycle();
      b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 16'h0010;
      en_after = -1; done_cyc = -1; rd = '0;
      for (int c = 0; c < 8 && done_cyc < 0; c++) begin
         @(negedge CLK);
         if (b_mem_en && en_after < 0) en_after = c;
         if (b_cpu_done) begin
            done_cyc = c; rd = b_cpu_rdata;
         end
         next_cycle();
      end
      b_cpu_req = 1'b0;
      check("lat1_issue_cycle", en_after, 1);
      check("lat1_done_cycle", done_cyc, 3);
      check("lat1_rdata", {16'h0, rd}, 32'h0000_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
